brake_light_decoder: RTL and testbench

- Receive-side decoder for the Ford tail-light lamp interface.
- Samples the six lamp lines L[2:0] and R[2:0] every clka edge. Reconstructs the driver command (left turn, right turn, brake) and checks each lamp stream against the legal pattern set.
- Sits after the brake-light FSM in system-level benches, or on a lamp bus, as a protocol checker and command recovery block.

---
 rtl/brake_light_decoder_pkg.sv | 34 +++
 rtl/brake_light_decoder_side.sv | 77 +++++++
 rtl/brake_light_decoder.sv | 76 +++++++
 tb/tb_brake_light_decoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/brake_light_decoder_pkg.sv
// Shared lamp codes, side-mode encoding and legality helpers for the
// tail-light lamp decoder.
package brake_light_decoder_pkg;

   localparam int unsigned LAMP_W = 3;

   localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;
   localparam logic [LAMP_W-1:0] LAMP_P1  = 3'b001;
   localparam logic [LAMP_W-1:0] LAMP_P2  = 3'b011;
   localparam logic [LAMP_W-1:0] LAMP_ON  = 3'b111;

   typedef enum logic [1:0] {
      MODE_OFF = 2'b00,
      MODE_ON  = 2'b01,
      MODE_SEQ = 2'b10,
      MODE_UNK = 2'b11
   } mode_e;

   // True for the four thermometer-style lamp values.
   function automatic logic lamp_legal(input logic [LAMP_W-1:0] v);
      return (v == LAMP_OFF) || (v == LAMP_P1) || (v == LAMP_P2) || (v == LAMP_ON);
   endfunction

   // Transition check between two legal values; off and steady-on are
   // always reachable, sequencing must step one phase at a time.
   function automatic logic trans_legal(input logic [LAMP_W-1:0] prev,
                                        input logic [LAMP_W-1:0] cur);
      return (cur == LAMP_OFF) || (cur == LAMP_ON) ||
             ((prev == LAMP_OFF) && (cur == LAMP_P1)) ||
             ((prev == LAMP_P1)  && (cur == LAMP_P2)) ||
             ((prev == LAMP_ON)  && (cur == LAMP_P1));
   endfunction

endpackage

// File: rtl/brake_light_decoder_side.sv
// lamp_side_tracker: per-side lamp stream tracker.
// Ports: clk, rst (sync active-high), lamp (current sample),
//        mode_c (mode after this edge), err_hit_c (this sample is a protocol
//        error), turns (wrapping completed-sequence count).
module lamp_side_tracker
   import brake_light_decoder_pkg::*;
#(
   parameter int unsigned TURN_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LAMP_W-1:0] lamp,
   output mode_e             mode_c,
   output logic              err_hit_c,
   output logic [TURN_W-1:0] turns
);

   logic [LAMP_W-1:0] prev;
   mode_e             mode;
   logic              first;
   logic              turn_hit_c;

   // Next mode, error and turn-completion for the current sample.
   always_comb begin
      mode_c     = mode;
      err_hit_c  = 1'b0;
      turn_hit_c = 1'b0;
      if (!first) begin
         if (!lamp_legal(lamp)) begin
            mode_c    = MODE_UNK;
            err_hit_c = 1'b1;
         end else begin
            // An illegal previous sample gives no basis for a transition check.
            if (lamp_legal(prev) && !trans_legal(prev, lamp)) begin
               err_hit_c = 1'b1;
            end
            case (lamp)
               LAMP_P1, LAMP_P2: mode_c = MODE_SEQ;
               LAMP_ON: begin
                  if (prev == LAMP_P2) begin
                     mode_c     = MODE_SEQ;
                     turn_hit_c = 1'b1;
                  end else begin
                     mode_c = MODE_ON;
                  end
               end
               default: begin
                  // All-off after the last phase is the inter-cycle gap of a turn.
                  if ((prev == LAMP_ON) && (mode == MODE_SEQ)) begin
                     mode_c = MODE_SEQ;
                  end else begin
                     mode_c = MODE_OFF;
                  end
               end
            endcase
         end
      end
   end

   // State update; the first edge after reset only captures prev.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= LAMP_OFF;
         mode  <= MODE_UNK;
         first <= 1'b1;
         turns <= '0;
      end else begin
         prev  <= lamp;
         mode  <= mode_c;
         first <= 1'b0;
         if (turn_hit_c) begin
            turns <= turns + TURN_W'(1);
         end
      end
   end

endmodule

// File: rtl/brake_light_decoder.sv
// brake_light_decoder: receive-side checker/decoder for the tail-light lamp bus.
// Ports: clka, RESTART (sync active-high), L/R lamp lines (bit0 innermost);
//        registered dec_left/dec_right/dec_brake/cmd_conflict/dec_valid,
//        proto_err pulse, saturating err_count, wrapping l_turns/r_turns.
module brake_light_decoder
   import brake_light_decoder_pkg::*;
#(
   parameter int unsigned ERR_W  = 8,
   parameter int unsigned TURN_W = 4
) (
   input  logic              clka,
   input  logic              RESTART,
   input  logic [LAMP_W-1:0] L,
   input  logic [LAMP_W-1:0] R,
   output logic              dec_left,
   output logic              dec_right,
   output logic              dec_brake,
   output logic              cmd_conflict,
   output logic              dec_valid,
   output logic              proto_err,
   output logic [ERR_W-1:0]  err_count,
   output logic [TURN_W-1:0] l_turns,
   output logic [TURN_W-1:0] r_turns
);

   mode_e l_mode_c;
   mode_e r_mode_c;
   logic  l_err_c;
   logic  r_err_c;
   logic  err_c;

   lamp_side_tracker #(.TURN_W(TURN_W)) u_left (
      .clk       (clka),
      .rst       (RESTART),
      .lamp      (L),
      .mode_c    (l_mode_c),
      .err_hit_c (l_err_c),
      .turns     (l_turns)
   );

   lamp_side_tracker #(.TURN_W(TURN_W)) u_right (
      .clk       (clka),
      .rst       (RESTART),
      .lamp      (R),
      .mode_c    (r_mode_c),
      .err_hit_c (r_err_c),
      .turns     (r_turns)
   );

   // Simultaneous errors on both sides count as a single event.
   assign err_c = l_err_c | r_err_c;

   // Decoded command and error accounting, registered from the next side modes.
   always_ff @(posedge clka) begin
      if (RESTART) begin
         dec_left     <= 1'b0;
         dec_right    <= 1'b0;
         dec_brake    <= 1'b0;
         cmd_conflict <= 1'b0;
         dec_valid    <= 1'b0;
         proto_err    <= 1'b0;
         err_count    <= '0;
      end else begin
         dec_left     <= (l_mode_c == MODE_SEQ);
         dec_right    <= (r_mode_c == MODE_SEQ);
         dec_brake    <= (l_mode_c == MODE_ON) || (r_mode_c == MODE_ON);
         cmd_conflict <= (l_mode_c == MODE_SEQ) && (r_mode_c == MODE_SEQ);
         dec_valid    <= (l_mode_c != MODE_UNK) && (r_mode_c != MODE_UNK);
         proto_err    <= err_c;
         if (err_c && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_brake_light_decoder.sv
// Directed self-checking bench for brake_light_decoder.
module tb_brake_light_decoder;

   logic       clka;
   logic       RESTART;
   logic [2:0] L;
   logic [2:0] R;
   logic       dec_left;
   logic       dec_right;
   logic       dec_brake;
   logic       cmd_conflict;
   logic       dec_valid;
   logic       proto_err;
   logic [7:0] err_count;
   logic [3:0] l_turns;
   logic [3:0] r_turns;

   int chk_cnt  = 0;
   int fail_cnt = 0;

   brake_light_decoder #(.ERR_W(8), .TURN_W(4)) dut (
      .clka         (clka),
      .RESTART      (RESTART),
      .L            (L),
      .R            (R),
      .dec_left     (dec_left),
      .dec_right    (dec_right),
      .dec_brake    (dec_brake),
      .cmd_conflict (cmd_conflict),
      .dec_valid    (dec_valid),
      .proto_err    (proto_err),
      .err_count    (err_count),
      .l_turns      (l_turns),
      .r_turns      (r_turns)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one sample and let it be taken at the next rising edge.
   task automatic apply(input logic [2:0] l, input logic [2:0] r);
      L = l;
      R = r;
      @(posedge clka);
      #1;
   endtask

   // Apply a sample and check the decoded outputs immediately after the edge.
   task automatic step(input string tag, input logic [2:0] l, input logic [2:0] r,
                       input logic el, input logic er, input logic eb,
                       input logic ev, input logic ee);
      apply(l, r);
      check({tag, ".left"},     32'(dec_left),     32'(el));
      check({tag, ".right"},    32'(dec_right),    32'(er));
      check({tag, ".brake"},    32'(dec_brake),    32'(eb));
      check({tag, ".conflict"}, 32'(cmd_conflict), 32'(el & er));
      check({tag, ".valid"},    32'(dec_valid),    32'(ev));
      check({tag, ".perr"},     32'(proto_err),    32'(ee));
   endtask

   task automatic restart(input string tag, input logic [2:0] l, input logic [2:0] r);
      RESTART = 1'b1;
      apply(l, r);
      RESTART = 1'b0;
      check({tag, ".rst_left"},  32'(dec_left),     32'd0);
      check({tag, ".rst_right"}, 32'(dec_right),    32'd0);
      check({tag, ".rst_brake"}, 32'(dec_brake),    32'd0);
      check({tag, ".rst_conf"},  32'(cmd_conflict), 32'd0);
      check({tag, ".rst_valid"}, 32'(dec_valid),    32'd0);
      check({tag, ".rst_perr"},  32'(proto_err),    32'd0);
      check({tag, ".rst_errc"},  32'(err_count),    32'd0);
      check({tag, ".rst_lt"},    32'(l_turns),      32'd0);
      check({tag, ".rst_rt"},    32'(r_turns),      32'd0);
   endtask

   initial begin
      RESTART = 1'b1;
      L = 3'b000;
      R = 3'b000;

      // Reset and idle lines
      restart("rst0", 3'b000, 3'b000);
      restart("rst1", 3'b000, 3'b000);
      step("idle0", 3'b000, 3'b000, 0, 0, 0, 0, 0);
      step("idle1", 3'b000, 3'b000, 0, 0, 0, 1, 0);
      step("idle2", 3'b000, 3'b000, 0, 0, 0, 1, 0);

      // Left turn, two full sequences with the all-off gap
      step("lseq1", 3'b001, 3'b000, 1, 0, 0, 1, 0);
      step("lseq2", 3'b011, 3'b000, 1, 0, 0, 1, 0);
      step("lseq3", 3'b111, 3'b000, 1, 0, 0, 1, 0);
      check("lseq.turns1", 32'(l_turns), 32'd1);
      step("lseq4", 3'b000, 3'b000, 1, 0, 0, 1, 0);
      step("lseq5", 3'b001, 3'b000, 1, 0, 0, 1, 0);
      step("lseq6", 3'b011, 3'b000, 1, 0, 0, 1, 0);
      step("lseq7", 3'b111, 3'b000, 1, 0, 0, 1, 0);
      check("lseq.turns2", 32'(l_turns), 32'd2);
      check("lseq.rturns", 32'(r_turns), 32'd0);
      check("lseq.errc",   32'(err_count), 32'd0);

      // Left sequencing while right holds brake
      restart("rst2", 3'b000, 3'b000);
      step("brk0", 3'b000, 3'b111, 0, 0, 0, 0, 0);
      step("brk1", 3'b001, 3'b111, 1, 0, 1, 1, 0);
      step("brk2", 3'b011, 3'b111, 1, 0, 1, 1, 0);
      step("brk3", 3'b111, 3'b111, 1, 0, 1, 1, 0);
      check("brk.lturns", 32'(l_turns), 32'd1);

      // Repeated phase, then an illegal right value
      step("err0", 3'b001, 3'b000, 1, 0, 0, 1, 0);
      step("err1", 3'b001, 3'b000, 1, 0, 0, 1, 1);
      check("err.cnt1", 32'(err_count), 32'd1);
      step("err2", 3'b000, 3'b000, 0, 0, 0, 1, 0);
      step("err3", 3'b000, 3'b101, 0, 0, 0, 0, 1);
      check("err.cnt2", 32'(err_count), 32'd2);
      step("err4", 3'b000, 3'b000, 0, 0, 0, 1, 0);
      check("err.cnt2b", 32'(err_count), 32'd2);

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) apply(3'b010, 3'b000);
      check("sat.perr",  32'(proto_err), 32'd1);
      check("sat.valid", 32'(dec_valid), 32'd0);
      check("sat.cnt",   32'(err_count), 32'd255);
      step("sat.end", 3'b000, 3'b000, 0, 0, 0, 1, 0);
      check("sat.hold", 32'(err_count), 32'd255);

      // Both sides sequencing together, then both illegal in one cycle
      restart("rst3", 3'b000, 3'b000);
      step("conf0", 3'b000, 3'b000, 0, 0, 0, 0, 0);
      step("conf1", 3'b000, 3'b000, 0, 0, 0, 1, 0);
      step("conf2", 3'b001, 3'b001, 1, 1, 0, 1, 0);
      step("conf3", 3'b011, 3'b011, 1, 1, 0, 1, 0);
      step("conf4", 3'b111, 3'b111, 1, 1, 0, 1, 0);
      check("conf.lturns", 32'(l_turns), 32'd1);
      check("conf.rturns", 32'(r_turns), 32'd1);
      step("both_ill", 3'b110, 3'b100, 0, 0, 0, 0, 1);
      check("both_ill.cnt", 32'(err_count), 32'd1);

      // Restart in the middle of a sequence
      step("mid0", 3'b000, 3'b000, 0, 0, 0, 1, 0);
      step("mid1", 3'b001, 3'b000, 1, 0, 0, 1, 0);
      restart("rst_mid", 3'b011, 3'b000);
      step("post0", 3'b111, 3'b000, 0, 0, 0, 0, 0);
      step("post1", 3'b111, 3'b000, 0, 0, 1, 1, 0);
      check("post.errc", 32'(err_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
      $finish;
   end

endmodule
